// File: rtl/tdm_pkg.sv
// tdm_pkg: shared slot geometry and frame-sync state encoding for the TDM demux.
package tdm_pkg;
    localparam int NUM_SLOTS = 4;
    localparam int SLOT_W = 2;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);
    typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;
endpackage

// File: rtl/tdm_slot_counter.sv
// tdm_slot_counter: modulo-NUM_SLOTS slot index with clear, load-to-1 and increment.
module tdm_slot_counter
    import tdm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              load,
    input  logic              clr,
    output logic [SLOT_W-1:0] cnt
);
    // Clear wins over load, load wins over increment; the 2-bit add wraps 3 -> 0.
    always_ff @(posedge clk or posedge rst)
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (load)
            cnt <= SLOT_W'(1);
        else if (inc)
            cnt <= cnt + 1'b1;
endmodule

// File: rtl/tdm_demux4.sv
// tdm_demux4: recovers four channels from a 1-bit TDM stream aligned by frame_start.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter bit ERR_RESYNC = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 din,
    input  logic                 frame_start,
    output logic [NUM_SLOTS-1:0] dout,
    output logic                 frame_valid,
    output logic [SLOT_W-1:0]    slot,
    output logic                 locked,
    output logic                 sync_err
);
    state_t               state, state_n;
    logic [NUM_SLOTS-2:0] shadow;
    logic                 cnt_inc, cnt_load, cnt_clr;
    logic                 cap, cap0, frame_done, err, resync;

    tdm_slot_counter u_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (cnt_inc),
        .load (cnt_load),
        .clr  (cnt_clr),
        .cnt  (slot)
    );

    always_comb begin
        state_n    = state;
        cnt_inc    = 1'b0;
        cnt_load   = 1'b0;
        cap        = 1'b0;
        cap0       = 1'b0;
        frame_done = 1'b0;
        err        = 1'b0;
        resync     = 1'b0;
        if (en && state == HUNT && frame_start) begin
            state_n  = LOCKED;
            cnt_load = 1'b1;
            cap0     = 1'b1;
        end else if (en && state == LOCKED) begin
            err        = frame_start && slot != '0;
            resync     = err && ERR_RESYNC;
            cnt_load   = resync;
            cap0       = resync;
            cnt_inc    = !resync;
            cap        = !resync && slot != LAST_SLOT;
            frame_done = !resync && slot == LAST_SLOT;
        end
        cnt_clr = state_n == HUNT;
    end

    // Slot 3 is never shadowed: it goes straight into dout with the stored slots.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state       <= HUNT;
            shadow      <= '0;
            dout        <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            locked      <= 1'b0;
        end else begin
            state       <= state_n;
            locked      <= state_n == LOCKED;
            frame_valid <= frame_done;
            sync_err    <= err;
            if (cap0)
                shadow[0] <= din;
            else if (cap)
                shadow[slot] <= din;
            if (frame_done)
                dout <= {din, shadow};
        end
endmodule
